ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
// - Instruction fetch unit: initiator side of the im read interface (im_addr/im_enable/im_result).
// - Owns the PC, drives im each cycle and captures im_result into an IF/ID output register.
// - Hands instructions to decode over a valid/ready handshake; accepts branch/jump redirects.
// - Detects fetch faults (misaligned, underflow, overflow of the im window) and halts fetch.
// PARAMETERS
// - START_ADDR  32'h0000_3000  reset PC; equals `IM_START_ADDRESS
// - IM_WORDS    1024           im depth in 32-bit words; valid window is [START_ADDR, START_ADDR+4*IM_WORDS)
// PORTS
// - clk              in   1   single clock; all state updates on posedge
// - reset_n          in   1   synchronous, active-low reset
// - im_addr          out  32  byte address to im, always equal to pc
// - im_enable        out  1   `IM_ENABLED when a fetch fires this cycle, else `IM_DISABLED
// - im_result        in   32  instruction word from im, combinational w.r.t. im_addr
// - redirect_valid   in   1   load redirect_target into PC this cycle
// - redirect_target  in   32  new PC (byte address)
// - out_valid        out  1   out_instr/out_pc hold a fetched instruction
// - out_ready        in   1   decode accepts the output this cycle
// - out_instr        out  32  fetched instruction word
// - out_pc           out  32  address of out_instr
// - fault            out  1   fetch halted on illegal address
// - fault_addr       out  32  PC that caused the fault
// - fetch_count      out  32  instructions fetched since reset, wraps at 2^32
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): pc=START_ADDR, state=RUN, out_valid=0, out_instr=0, out_pc=0,
//   fault=0, fault_addr=0, fetch_count=0; im_enable=`IM_DISABLED while reset_n=0.
// - addr_ok = (pc[1:0]==0) && (pc >= START_ADDR) && (pc - START_ADDR < 4*IM_WORDS); unsigned 32-bit compare.
// - fire = reset_n && state==RUN && addr_ok && !redirect_valid && (!out_valid || out_ready).
// - im_enable = fire; im_addr = pc always.
// - On fire: out_instr<=im_result, out_pc<=pc, out_valid<=1, pc<=pc+4 (mod 2^32), fetch_count++.
//   Latency: instruction at pc is on out_* one cycle after the fire cycle; 1 instr/cycle when out_ready=1.
// - out_ready && out_valid && !fire: out_valid<=0. Stall (out_valid && !out_ready): out_*, pc held.
// - redirect_valid (highest priority, accepted even when stalled or in FAULT): pc<=redirect_target,
//   out_valid<=0 (squash held instr), state<=RUN, fault<=0; no fetch in that cycle.
// - States: RUN, FAULT. RUN->FAULT when state==RUN, !addr_ok, !redirect_valid: fault<=1, fault_addr<=pc.
//   FAULT: no fetch, pc frozen; pending out_* still drains via out_ready. FAULT->RUN only by redirect.
//   Redirect to a bad target re-enters FAULT the following cycle with fault_addr=that target.
// - Wrap: pc+4 from 32'hFFFF_FFFC yields 0, which is below START_ADDR -> FAULT; pc=START_ADDR-4 -> FAULT.
// - Last legal word START_ADDR+4*IM_WORDS-4 is fetched; next pc faults.
// - Reset mid-stall or mid-fault overrides everything; no instruction survives reset.
// STRUCTURE
// - im.h: `IM_START_ADDRESS, `IM_ENABLED, `IM_DISABLED (existing); add `IM_WORDS, `IFU_STATE_RUN,
//   `IFU_STATE_FAULT, `IFU_PC_STEP (4).
// - Sub-module ifu_addr_check (combinational): pc -> addr_ok, parameterised by START_ADDR/IM_WORDS.
// - Top holds pc, state, output register and fetch_count; drives an im instance in the bench.
// TESTING
// - Reset, out_ready=1, im preloaded: out_pc = 32'h3000,32'h3004,32'h3008 on consecutive cycles,
//   out_instr matches im words 0,1,2; fetch_count=3.
// - out_ready=0 for 3 cycles after first out_valid: out_pc stays 32'h3000, im_enable=`IM_DISABLED,
//   pc stays 32'h3004; release -> 32'h3004 next.
// - redirect_valid=1, target 32'h3100 while stalled: next cycle out_valid=0; following out_pc=32'h3100.
// - Redirect to 32'h2FFC (START-4, underflow): fault=1, fault_addr=32'h2FFC, im_enable stays disabled.
// - Redirect to 32'h3002 (misaligned): fault=1, fault_addr=32'h3002; redirect to 32'h3000 clears fault.
// - Run to 32'h3FFC (IM_WORDS=1024): that word is delivered, then fault=1 with fault_addr=32'h4000;
//   assert reset_n=0 for one cycle -> all outputs at reset values, pc=32'h3000.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit and its im read port.
package ifu_pkg;

  localparam logic [31:0] IM_START_ADDRESS = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 1024;
  localparam logic        IM_ENABLED       = 1'b1;
  localparam logic        IM_DISABLED      = 1'b0;
  localparam logic [31:0] IFU_PC_STEP      = 32'd4;

  typedef enum logic [0:0] {
    StRun,
    StFault
  } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// im read bus: the fetch unit is master (address/enable out), the memory is slave.
interface ifu_if;
  logic [31:0] im_addr;
  logic        im_enable;
  logic [31:0] im_result;

  modport master (
    output im_addr,
    output im_enable,
    input  im_result
  );

  modport slave (
    input  im_addr,
    input  im_enable,
    output im_result
  );
endinterface

// File: rtl/ifu_addr_check.sv
// Combinational legality check of a fetch address against the im window.
module ifu_addr_check #(
  parameter logic [31:0] START_ADDR = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 1024
) (
  input  logic [31:0] pc_i,
  output logic        addr_ok_o
);

  localparam logic [32:0] WinBytes = 33'(IM_WORDS) << 2;

  logic [31:0] offset;

  always_comb begin
    offset    = pc_i - START_ADDR;
    addr_ok_o = (pc_i[1:0] == 2'b00) && (pc_i >= START_ADDR) && ({1'b0, offset} < WinBytes);
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, reads im each cycle and presents an IF/ID register.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] START_ADDR = IM_START_ADDRESS,
  parameter int unsigned IM_WORDS   = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  ifu_if.master       im,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        addr_ok;
  logic        fire;

  ifu_addr_check #(
    .START_ADDR (START_ADDR),
    .IM_WORDS   (IM_WORDS)
  ) u_addr_check (
    .pc_i      (pc_q),
    .addr_ok_o (addr_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StRun;
      pc_q          <= START_ADDR;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      fault_q       <= 1'b0;
      fault_addr_q  <= 32'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StRun;
    end else if (state_q == StRun && !addr_ok) begin
      state_d = StFault;
    end
  end

  always_comb begin
    fire = reset_n && (state_q == StRun) && addr_ok && !redirect_valid &&
           (!out_valid_q || out_ready);
    im.im_enable = fire ? IM_ENABLED : IM_DISABLED;
    im.im_addr   = pc_q;
  end

  // Redirect outranks everything: it squashes the held instruction and clears a fault.
  always_comb begin
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      fault_d     = 1'b0;
    end else begin
      if (fire) begin
        out_instr_d   = im.im_result;
        out_pc_d      = pc_q;
        out_valid_d   = 1'b1;
        pc_d          = pc_q + IFU_PC_STEP;
        fetch_count_d = fetch_count_q + 32'd1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (state_q == StRun && !addr_ok) begin
        fault_d      = 1'b1;
        fault_addr_d = pc_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifu.sv
// Directed table-driven bench for ifu with a behavioural im behind the read interface.
module tb_ifu;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  ifu_if im_bus ();

  logic [31:0] mem [1024];
  logic [31:0] im_off;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - 32'h0000_3000) >> 2;
    return 32'hC0DE_0000 ^ (idx * 32'h0001_0003);
  endfunction

  assign im_off = im_bus.im_addr - 32'h0000_3000;
  assign im_bus.im_result = (im_bus.im_addr >= 32'h3000 && im_off < 32'h1000)
                            ? mem[im_off[11:2]] : 32'hDEAD_BEEF;

  ifu u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .im              (im_bus.master),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rv;
    logic [31:0] tgt;
    logic        en;
    logic        valid;
    logic        chk_out;
    logic [31:0] opc;
    logic        flt;
    logic [31:0] faddr;
    logic [31:0] ia;
    logic [31:0] cnt;
  } vec_t;

  vec_t vec [23];

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
    reset_n         = r;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic apply(input vec_t v, input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    drive(v.rst_n, v.ready, v.rv, v.tgt);
    #1;
    chk({tag, ".im_enable"}, {31'h0, im_bus.im_enable}, {31'h0, v.en});
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, v.valid});
    chk({tag, ".fault"}, {31'h0, fault}, {31'h0, v.flt});
    chk({tag, ".fault_addr"}, fault_addr, v.faddr);
    chk({tag, ".im_addr"}, im_bus.im_addr, v.ia);
    chk({tag, ".fetch_count"}, fetch_count, v.cnt);
    if (v.chk_out) begin
      chk({tag, ".out_pc"}, out_pc, v.opc);
      chk({tag, ".out_instr"}, out_instr, v.valid ? word_at(v.opc) : 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word_at(32'h3000 + 32'(i) * 4);

    //           rst ready rv  tgt           en valid chk opc         flt faddr         ia            cnt
    vec[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0,    32'h3000, 32'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h3004, 32'd1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h3004, 32'd1};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h3004, 32'd1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h3004, 32'd1};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3004, 1'b0, 32'h0,    32'h3008, 32'd2};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3008, 1'b0, 32'h0,    32'h300C, 32'd3};
    vec[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h3008, 1'b0, 32'h0,    32'h300C, 32'd3};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 32'h3100,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h3100, 32'd3};
    vec[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3100, 1'b0, 32'h0,    32'h3104, 32'd4};
    vec[10] = '{1'b1, 1'b1, 1'b1, 32'h2FFC,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    32'h2FFC, 32'd4};
    vec[11] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h2FFC, 32'h2FFC, 32'd4};
    vec[12] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h2FFC, 32'h2FFC, 32'd4};
    vec[13] = '{1'b1, 1'b1, 1'b1, 32'h3002,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h2FFC, 32'h3002, 32'd4};
    vec[14] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3002, 32'h3002, 32'd4};
    vec[15] = '{1'b1, 1'b1, 1'b1, 32'h3000,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3002, 32'h3000, 32'd4};
    vec[16] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h3002, 32'h3004, 32'd5};
    vec[17] = '{1'b1, 1'b0, 1'b1, 32'h3FFC,  1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h3002, 32'h3FFC, 32'd5};
    vec[18] = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3FFC, 1'b0, 32'h3002, 32'h4000, 32'd6};
    vec[19] = '{1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 32'h3FFC, 1'b1, 32'h4000, 32'h4000, 32'd6};
    vec[20] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h4000, 32'h4000, 32'd6};
    vec[21] = '{1'b0, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0,    32'h3000, 32'd0};
    vec[22] = '{1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    32'h3004, 32'd1};

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) apply(vec[i], i);

    // Full-window run with out_ready=1: every word streams out, then the PC past the end faults.
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("run%0d.out_pc", i), out_pc, 32'h3000 + 32'(i) * 4);
      chk($sformatf("run%0d.out_instr", i), out_instr, mem[i]);
      chk($sformatf("run%0d.out_valid", i), {31'h0, out_valid}, 32'h1);
    end
    chk("run.fetch_count", fetch_count, 32'd1024);
    chk("run.im_enable_at_end", {31'h0, im_bus.im_enable}, {31'h0, IM_DISABLED});
    @(posedge clk);
    #1;
    chk("end.fault", {31'h0, fault}, 32'h1);
    chk("end.fault_addr", fault_addr, 32'h4000);
    chk("end.out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("end.pc_frozen", im_bus.im_addr, 32'h4000);
    chk("end.fetch_count_held", fetch_count, 32'd1024);

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("rst.im_enable", {31'h0, im_bus.im_enable}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst.fault", {31'h0, fault}, 32'h0);
    chk("rst.fault_addr", fault_addr, 32'h0);
    chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst.out_pc", out_pc, 32'h0);
    chk("rst.out_instr", out_instr, 32'h0);
    chk("rst.fetch_count", fetch_count, 32'h0);
    chk("rst.pc", im_bus.im_addr, 32'h3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
